// File: rtl/pwm_carrier_sequencer_if.sv
// Duty-word handshake between the FOC current loop and the PWM carrier sequencer.
//   duty_in     NCH*N  new per-phase duty words, channel i in bits [i*N +: N]
//   duty_valid  1      duty_in holds a word to hand over
//   duty_ready  1      sequencer shadow register is empty and will take the word
// A word transfers on any clk edge where duty_valid & duty_ready.
interface pwm_carrier_sequencer_if #(
    parameter int unsigned N   = 6,
    parameter int unsigned NCH = 3
);
    logic [NCH*N-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    // Producer side (current loop / testbench)
    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    // Consumer side (sequencer)
    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/pwm_carrier_sequencer.sv
// Sequencer for the N-bit up/down triangular PWM carrier of the FOC PWM stage.
// Holds the carrier in reset while idle, divides clk into the carrier tick,
// double-buffers the per-phase duty words (swapped only at the carrier valley),
// and flags each carrier peak (ADC trigger) and valley (period done).
// Ports:
//   clk, rst       system clock; synchronous active-high reset
//   start, stop    pulses: start honoured in IDLE, stop honoured in RUN
//   presc          tick divider, tick every presc+1 cycles (latched at ARM / valley)
//   duty_if        duty word handshake (slave side)
//   carrier_cnt    current carrier count (value before the carrier updates)
//   carrier_en     carrier tick, decoded from the registered prescaler count
//   carrier_nrst   active-low carrier reset, low while idle
//   duty_active    duty words in force for the comparators
//   adc_trig       1-cycle pulse after each peak
//   period_done    1-cycle pulse after each valley
//   busy           sequencer not idle
module pwm_carrier_sequencer #(
    parameter int unsigned N   = 6,
    parameter int unsigned NCH = 3,
    parameter int unsigned PW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [PW-1:0]         presc,
    pwm_carrier_sequencer_if.slave duty_if,
    input  logic [N-1:0]          carrier_cnt,
    output logic                  carrier_en,
    output logic                  carrier_nrst,
    output logic [NCH*N-1:0]      duty_active,
    output logic                  adc_trig,
    output logic                  period_done,
    output logic                  busy
);

    localparam int unsigned DW      = NCH * N;
    localparam logic [N-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PW-1:0]   presc_lat;
    logic [PW-1:0]   pc;
    logic            dir_down;
    logic [DW-1:0]   shadow;
    logic            shadow_empty;

    logic            running;
    logic            tick;
    logic            peak_evt;
    logic            valley_evt;
    logic            accept;
    logic            swap;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stop is only looked at in RUN, start only in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)      state_nxt = S_ARM;
            S_ARM:                   state_nxt = S_RUN;
            S_RUN:   if (stop)       state_nxt = S_DRAIN;
            S_DRAIN: if (valley_evt) state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // State decode: carrier released from ARM onward, prescaler only counts in RUN/DRAIN
    always_comb begin
        carrier_nrst = 1'b0;
        running      = 1'b0;
        case (state)
            S_ARM: begin
                carrier_nrst = 1'b1;
            end
            S_RUN, S_DRAIN: begin
                carrier_nrst = 1'b1;
                running      = 1'b1;
            end
            default: begin
                carrier_nrst = 1'b0;
            end
        endcase
        busy       = (state != S_IDLE);
        carrier_en = running && (pc == '0);
    end

    // Extreme-value events; dir_down suppresses the repeated extreme sample
    always_comb begin
        tick       = carrier_en;
        peak_evt   = tick && (carrier_cnt == CNT_MAX) && !dir_down;
        valley_evt = tick && (carrier_cnt == '0) && dir_down;
        accept     = duty_if.duty_valid && shadow_empty;
        swap       = !shadow_empty && ((state == S_ARM) || valley_evt);
    end

    // Prescaler, carrier direction and period latch
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            presc_lat <= '0;
            dir_down  <= 1'b0;
        end else if (state == S_ARM) begin
            presc_lat <= presc;
            pc        <= presc;
            dir_down  <= 1'b0;
        end else if (running) begin
            if (tick) begin
                pc <= presc_lat;
            end else begin
                pc <= pc - PW'(1);
            end
            if (peak_evt) begin
                dir_down <= 1'b1;
            end else if (valley_evt) begin
                dir_down <= 1'b0;
            end
            // A new divider only takes hold at a period boundary
            if (valley_evt) begin
                presc_lat <= presc;
            end
        end
    end

    // Event pulses, one cycle after the detecting tick
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_trig    <= 1'b0;
            period_done <= 1'b0;
        end else begin
            adc_trig    <= peak_evt;
            period_done <= valley_evt;
        end
    end

    // Duty double buffer: incoming words only ever land in the shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow       <= '0;
            shadow_empty <= 1'b1;
            duty_active  <= '0;
        end else if (swap) begin
            duty_active  <= shadow;
            shadow_empty <= 1'b1;
        end else if (accept) begin
            shadow       <= duty_if.duty_in;
            shadow_empty <= 1'b0;
        end
    end

    assign duty_if.duty_ready = shadow_empty;

endmodule
